// File: rtl/divfp_seq.sv
// divfp_seq - sequential signed fixed-point divider.
//
// Computes p = trunc_toward_zero((a * 2^OFR) / b), saturated to the signed
// OWIDTH range. The operands share IFR fraction bits, so IFR cancels out of
// the quotient. A restoring divider works on magnitudes and produces one
// quotient bit per clock. The sign is applied after the magnitude division.
//
// Ports:
//   clk   - clock; all state changes on its rising edge
//   rst   - asynchronous, active-low reset
//   a     - signed dividend, WIDTH bits, IFR fraction bits
//   b     - signed divisor, WIDTH bits, IFR fraction bits
//   start - request; the requester holds it high until done is seen
//   ack   - one-cycle pulse confirming operand capture
//   done  - result valid; held while start stays high
//   p     - signed quotient, OWIDTH bits, OFR fraction bits
//   dbz   - divide-by-zero flag, valid with done
//   ovf   - saturation flag, valid with done
module divfp_seq #(
    parameter int WIDTH  = 8,
    parameter int IFR    = 4,
    parameter int OWIDTH = 16,
    parameter int OFR    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              start,
    output logic              ack,
    output logic              done,
    output logic [OWIDTH-1:0] p,
    output logic              dbz,
    output logic              ovf
);

    // The dividend and the divisor carry the same IFR fraction bits, so the
    // pre-shift of the dividend depends on OFR alone.
    localparam int QSHIFT = (OFR + IFR) - IFR;
    localparam int N      = WIDTH + OFR;
    localparam int CW     = $clog2(N + 1);
    localparam int XW     = ((N > OWIDTH) ? N : OWIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     dvd;      // dividend magnitude, shifted out MSB first
    logic [N-1:0]     q;        // quotient magnitude, shifted in LSB first
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder, always < dvs
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;
    logic             neg;      // quotient sign (a XOR b)
    logic             aneg;     // dividend sign, selects the divide-by-zero bound
    logic [OWIDTH+1:0] fin_res; // {dbz, ovf, p}

    // Magnitude is formed one bit wider than the operand, so that the most
    // negative value comes out exact. The result always fits in WIDTH
    // unsigned bits.
    function automatic logic [WIDTH-1:0] absv(input logic [WIDTH-1:0] x);
        return WIDTH'(x[WIDTH-1] ? (~{x[WIDTH-1], x} + 1'b1) : {x[WIDTH-1], x});
    endfunction

    // Apply the sign, then saturate to OWIDTH. Divide by zero yields the bound
    // in the direction of the dividend. A zero magnitude always gives +0.
    function automatic logic [OWIDTH+1:0] finish_q(
        input logic [N-1:0] qm,
        input logic         ng,
        input logic         zb,
        input logic         an
    );
        logic [XW-1:0]     qx, maxp, minm;
        logic [OWIDTH-1:0] pmax, pmin;
        qx   = XW'(qm);
        maxp = {{(XW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
        minm = maxp + 1'b1;
        pmax = {1'b0, {(OWIDTH-1){1'b1}}};
        pmin = ~pmax;
        if (zb)
            return {2'b10, (an ? pmin : pmax)};
        if (ng) begin
            if (qx > minm)
                return {2'b01, pmin};
            return {2'b00, OWIDTH'(~qx + 1'b1)};
        end
        if (qx > maxp)
            return {2'b01, pmax};
        return {2'b00, OWIDTH'(qx)};
    endfunction

    // One restoring step: the remainder is shifted, and the next dividend bit
    // is brought in. The divisor is subtracted when it fits.
    always_comb begin
        qbit   = ({rem, dvd[N-1]} >= {1'b0, dvs});
        rem_nx = WIDTH'({rem, dvd[N-1]});
        if (qbit)
            rem_nx = WIDTH'({rem, dvd[N-1]} - {1'b0, dvs});
    end

    assign fin_res = finish_q(q, neg, (dvs == '0), aneg);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (b == '0) ? FIN : CALC;
            CALC: if (cnt == CW'(N - 1)) state_nx = FIN;
            FIN:  state_nx = DONE;
            DONE: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            q     <= '0;
            dvs   <= '0;
            rem   <= '0;
            neg   <= 1'b0;
            aneg  <= 1'b0;
            ack   <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            ack   <= (state == IDLE) && start;
            // done rises one edge after DONE is entered. It falls on the same
            // edge that returns to IDLE, so it never overlaps ack.
            done  <= (state == DONE) && start;
            case (state)
                IDLE: if (start) begin
                    neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                    aneg <= a[WIDTH-1];
                    dvd  <= N'(absv(a)) << QSHIFT;
                    dvs  <= absv(b);
                    rem  <= '0;
                    q    <= '0;
                    cnt  <= '0;
                end
                CALC: begin
                    dvd <= dvd << 1;
                    rem <= rem_nx;
                    q   <= {q[N-2:0], qbit};
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    p   <= fin_res[OWIDTH-1:0];
                    ovf <= fin_res[OWIDTH];
                    dbz <= fin_res[OWIDTH+1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divfp_seq.sv
module tb_divfp_seq;

    localparam int N = 13;  // WIDTH + OFR with default parameters

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b;
    logic        start;
    logic        ack0, done0, dbz0, ovf0;
    logic        ack1, done1, dbz1, ovf1;
    logic [15:0] p0;
    logic [9:0]  p1;

    int errors = 0;
    int checks = 0;

    // expectations for the operation in flight
    bit exp_set = 1'b0;
    int e0p, e1p;
    bit e0d, e0o, e1d, e1o;
    int rises0 = 0, acks0 = 0;
    bit done0_q = 1'b0;

    always #5 clk = ~clk;

    divfp_seq dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
        .ack(ack0), .done(done0), .p(p0), .dbz(dbz0), .ovf(ovf0)
    );

    divfp_seq #(.OWIDTH(10)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
        .ack(ack1), .done(done1), .p(p1), .dbz(dbz1), .ovf(ovf1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: exact rational quotient, truncated toward zero, then clamped.
    function automatic void model(input int ai, input int bi, input int ow,
                                  output int pe, output bit dz, output bit ov);
        longint one, mx, mn, num, qq;
        one = 1;
        mx  = (one << (ow - 1)) - 1;
        mn  = -mx - 1;
        dz  = 1'b0;
        ov  = 1'b0;
        if (bi == 0) begin
            dz = 1'b1;
            pe = int'((ai >= 0) ? mx : mn);
            return;
        end
        num = longint'(ai) * 32;
        qq  = num / longint'(bi);
        if (qq > mx) begin
            pe = int'(mx); ov = 1'b1;
        end else if (qq < mn) begin
            pe = int'(mn); ov = 1'b1;
        end else begin
            pe = int'(qq);
        end
    endfunction

    // Per-cycle compare of both DUTs against the current expectation.
    always @(negedge clk) begin
        if (rst) begin
            chk("ack_done_overlap", int'((ack0 && done0) || (ack1 && done1)), 0);
            if (ack0) acks0++;
            if (done0 && !done0_q) rises0++;
            if (done0 || done1) begin
                chk("done_expected", int'(exp_set), 1);
                if (exp_set) begin
                    chk("p16", int'($signed(p0)), e0p);
                    chk("dbz16", int'(dbz0), int'(e0d));
                    chk("ovf16", int'(ovf0), int'(e0o));
                    chk("p10", int'($signed(p1)), e1p);
                    chk("dbz10", int'(dbz1), int'(e1d));
                    chk("ovf10", int'(ovf1), int'(e1o));
                end
            end
            done0_q <= done0;
        end else begin
            done0_q <= 1'b0;
        end
    end

    task automatic run_op(input int ta, input int tb, input int hold);
        int e, r0, k0;
        model(ta, tb, 16, e0p, e0d, e0o);
        model(ta, tb, 10, e1p, e1d, e1o);
        exp_set = 1'b1;
        r0 = rises0;
        k0 = acks0;
        a = 8'(ta);
        b = 8'(tb);
        start = 1'b1;
        @(negedge clk);                        // after capture edge 0
        chk("ack_pulse", int'(ack0 && ack1), 1);
        e = 0;
        while (!done0 && e < 40) begin
            @(negedge clk);
            e++;
            a = 8'($urandom);                  // must be ignored after capture
            b = 8'($urandom);
        end
        chk("latency", e, (tb == 0) ? 2 : N + 2);
        chk("done_both", int'(done1), 1);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", int'(done0 || done1), 0);
        chk("one_done", rises0 - r0, 1);
        chk("one_ack", acks0 - k0, 1);
        exp_set = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe;
        bit dz, ov;
        int r0;

        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_p", int'(p0), 0);
        chk("rst_flags", int'({done0, ack0, dbz0, ovf0}), 0);
        rst = 1'b1;
        @(negedge clk);

        // hand-computed values pinning the model
        model(24, 8, 16, pe, dz, ov);   chk("model_24_8", pe, 96);
        model(-1, 3, 16, pe, dz, ov);   chk("model_m1_3", pe, -10);
        model(127, 1, 10, pe, dz, ov);  chk("model_127_1_ovf", pe + int'(ov) * 10000, 10511);
        model(-5, 0, 16, pe, dz, ov);   chk("model_m5_0", pe + int'(dz) * 100000, 67232);

        // directed cases
        run_op(24, 8, 0);     chk("lit_3p0", int'($signed(p0)), 96);
        run_op(-24, 8, 0);    chk("lit_m3p0", int'($signed(p0)), -96);
        run_op(1, 3, 0);      chk("lit_1_3", int'($signed(p0)), 10);
        run_op(-1, -3, 1);    chk("lit_m1_m3", int'($signed(p0)), 10);
        run_op(-1, 3, 0);     chk("lit_m1_3", int'($signed(p0)), -10);
        run_op(127, 1, 0);    chk("lit_sat_hi", int'($signed(p1)), 511);
        run_op(-128, 1, 0);   chk("lit_sat_lo", int'($signed(p1)), -512);
        run_op(-128, -1, 0);
        run_op(-128, -128, 0);
        run_op(0, -7, 0);     chk("lit_zero", int'(p0), 0);
        run_op(5, 0, 0);      chk("lit_dbz_pos", int'($signed(p0)), 32767);
        run_op(-5, 0, 2);     chk("lit_dbz_neg", int'($signed(p0)), -32768);

        // long hold in DONE, idle, then the same request again
        run_op(37, -9, 5);
        repeat (4) @(negedge clk);
        run_op(37, -9, 0);

        // abort mid-CALC by reset
        exp_set = 1'b0;
        r0 = rises0;
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_p", int'(p0), 0);
        chk("abort_flags", int'({done0, ack0, dbz0, ovf0, done1, ack1}), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", rises0 - r0, 0);
        run_op(16, 16, 0);    chk("lit_after_rst", int'($signed(p0)), 32);

        // randomized requests
        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 255)) - 128;
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            run_op(ra, rb, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divfp_seq.md
DIVFP_SEQ -- requirements
Module: divfp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (signed).
REQ-002 The block SHALL have parameter IFR, default 4, meaning the number of fraction bits in both operands.
REQ-003 The block SHALL have parameter OWIDTH, default 16, meaning the quotient width in bits (signed).
REQ-004 The block SHALL have parameter OFR, default 5, meaning the number of quotient fraction bits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port a, input, WIDTH bits: signed dividend, IFR fraction bits.
REQ-008 The block SHALL have port b, input, WIDTH bits: signed divisor, IFR fraction bits.
REQ-009 The block SHALL have port start, input, 1 bit: request, held high by the requester until done is seen.
REQ-010 The block SHALL have port ack, output, 1 bit: one-cycle pulse confirming operand capture.
REQ-011 The block SHALL have port done, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port p, output, OWIDTH bits: signed quotient, OFR fraction bits.
REQ-013 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid with done.
REQ-014 The block SHALL have port ovf, output, 1 bit: saturation flag, valid with done.

Function
REQ-015 The block SHALL compute p = trunc_toward_zero((a_int * 2^OFR) / b_int), saturated to the signed OWIDTH range; IFR cancels.
REQ-016 Division SHALL be restoring, on magnitudes: |a| extended to N = WIDTH+OFR bits (left-shifted by OFR), with one quotient bit per cycle. The sign SHALL be applied as a XOR b.
REQ-017 Magnitudes SHALL be formed at WIDTH+1 bits so that a or b = -2^(WIDTH-1) is exact.
REQ-018 FSM states SHALL be IDLE, CALC, FIN and DONE.
REQ-019 IDLE with start=1 at an edge: the block SHALL capture a and b, and ack SHALL be 1 for exactly the next cycle.
  - If b != 0, the next state SHALL be CALC.
  - If b == 0, the next state SHALL be FIN.
REQ-020 CALC SHALL last exactly N cycles, counted by an internal counter, and then go to FIN.
REQ-021 FIN SHALL last one cycle: apply the sign, saturate, and register p, dbz and ovf, then go to DONE.
REQ-022 DONE SHALL hold done=1 with p, dbz and ovf stable while start=1.
  - The first edge with start=0 SHALL return to IDLE with done=0.
  - p SHALL hold its value until the next FIN.
REQ-023 Latency SHALL be as follows (edge 0 = capture edge):
  - b != 0: done=1 after edge N+2.
  - b == 0: done=1 after edge 2.
REQ-024 start, a and b changes during CALC or FIN SHALL be ignored. Operands SHALL be sampled only at the IDLE capture edge.
REQ-025 Saturation rule: if the signed result exceeds 2^(OWIDTH-1)-1 or is below -2^(OWIDTH-1), p SHALL be clamped to that bound and ovf=1.
REQ-026 Divide by zero: p SHALL be the maximum positive value if a >= 0, else the minimum negative value, with dbz=1 and ovf=0.
REQ-027 ack and done SHALL never be high in the same cycle.
REQ-028 A result of magnitude zero SHALL give p=0 regardless of sign; negative zero is not permitted.

Reset
REQ-029 While rst=0: state=IDLE, p=0, done=0, ack=0, dbz=0, ovf=0, and the counter and datapath registers SHALL be 0.
REQ-030 Assertion of rst in any state, including mid-CALC, SHALL abort the operation immediately, with no done pulse for that operation.
REQ-031 After rst rises, the first start=1 edge SHALL be treated as a fresh capture from IDLE.

Verification
REQ-032 Defaults, a=24 (1.5), b=8 (0.5), start held: ack=1 in cycle 1, done=1 after edge 15, p=96 (3.0), dbz=0, ovf=0.
REQ-033 a=-24, b=8 -> p=-96. a=1, b=3 -> p=10. a=-1, b=-3 -> p=10. a=-1, b=3 -> p=-10 (truncation toward zero).
REQ-034 OWIDTH=10 override, a=127, b=1 -> p=511, ovf=1. a=-128, b=1 -> p=-512, ovf=1.
REQ-035 a=5, b=0 -> done after edge 2, p=32767, dbz=1. a=-5, b=0 -> p=-32768, dbz=1.
REQ-036 rst pulled low at CALC cycle 6, then released, then a new request a=16, b=16: p=32 and exactly one done for the new request.
REQ-037 start held high across DONE for 5 cycles: done stays 1 and p stays stable. Drop start: IDLE next edge. Re-raise start: a new ack, and no second result without a new ack.
